// File: rtl/pc_unit.sv
// Program counter with next-PC selection (sequential, branch, jump, trap, mret), stall and misaligned-target faulting.
// Optional compressed-instruction support is enabled by defining PC_RVC_EN (adds inst_c, 2-byte alignment).
//
// state | meaning
// BOOT  | first cycle after reset release; pc holds RESET_VECTOR, requests ignored
// RUN   | normal fetch; next PC chosen by request priority
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_en,
    input  logic            mret_en,
`ifdef PC_RVC_EN
    input  logic            inst_c,
`endif
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_next;
    logic            mis_next;
    logic            jump_bad;
    logic            branch_bad;
    logic            mret_bad;

`ifdef PC_RVC_EN
    assign inc        = inst_c ? XLEN'(2) : XLEN'(4);
    assign jump_bad   = jump_target[0];
    assign branch_bad = branch_target[0];
    assign mret_bad   = epc[0];
`else
    assign inc        = XLEN'(4);
    assign jump_bad   = |jump_target[1:0];
    assign branch_bad = |branch_target[1:0];
    assign mret_bad   = |epc[1:0];
`endif

    assign pc_plus = pc_out + inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // A misaligned redirect is turned into a trap with the bad target saved in epc.
    always_comb begin
        pc_next     = pc_out;
        epc_next    = epc;
        mis_next    = 1'b0;
        fetch_valid = (state == RUN);
        if (state == RUN) begin
            if (trap_en) begin
                pc_next  = TRAP_VECTOR;
                epc_next = pc_out;
            end else if (mret_en) begin
                if (mret_bad) begin
                    pc_next  = TRAP_VECTOR;
                    mis_next = 1'b1;
                end else begin
                    pc_next = epc;
                end
            end else if (jump_en) begin
                if (jump_bad) begin
                    pc_next  = TRAP_VECTOR;
                    epc_next = jump_target;
                    mis_next = 1'b1;
                end else begin
                    pc_next = jump_target;
                end
            end else if (branch_taken) begin
                if (branch_bad) begin
                    pc_next  = TRAP_VECTOR;
                    epc_next = branch_target;
                    mis_next = 1'b1;
                end else begin
                    pc_next = branch_target;
                end
            end else if (!stall) begin
                pc_next = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out     <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            pc_out     <= pc_next;
            epc        <= epc_next;
            misaligned <= mis_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: reset/boot, stall, priority, trap/mret, misaligned faults, wrap, async reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        trap_en;
    logic        mret_en;
`ifdef PC_RVC_EN
    logic        inst_c;
`endif
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic [31:0] epc;
    logic        misaligned;

    int n_cmp = 0;
    int n_err = 0;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .trap_en       (trap_en),
        .mret_en       (mret_en),
`ifdef PC_RVC_EN
        .inst_c        (inst_c),
`endif
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .fetch_valid   (fetch_valid),
        .epc           (epc),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        stall = 0; branch_taken = 0; jump_en = 0; trap_en = 0; mret_en = 0;
        branch_target = '0; jump_target = '0;
`ifdef PC_RVC_EN
        inst_c = 0;
`endif
    endtask

    initial begin
        reset = 0;
        idle();
        tick(); tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);

        // release reset; a jump during BOOT must be ignored
        reset = 1;
        jump_en = 1; jump_target = 32'h80;
        #1;
        chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
        chk("boot_plus", pc_plus, 32'h4);
        tick();
        chk("boot_pc", pc_out, 32'h0);
        chk("run_fv", {31'b0, fetch_valid}, 32'h1);
        idle();
        tick(); chk("seq4", pc_out, 32'h4);
        chk("plus8", pc_plus, 32'h8);
        tick(); chk("seq8", pc_out, 32'h8);

        stall = 1;
        tick(); chk("stall1", pc_out, 32'h8);
        tick(); chk("stall2", pc_out, 32'h8);
        tick(); chk("stall3", pc_out, 32'h8);
        chk("stall_plus", pc_plus, 32'hC);
        branch_taken = 1; branch_target = 32'h40;
        tick(); chk("br_over_stall", pc_out, 32'h40);
        idle();

        jump_en = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        tick(); chk("jmp_over_br", pc_out, 32'h80);
        idle();
        trap_en = 1; jump_en = 1; jump_target = 32'h200;
        tick(); chk("trap_over_jmp", pc_out, 32'h100);
        chk("trap_epc", epc, 32'h80);
        idle();
        tick(); chk("after_trap", pc_out, 32'h104);

        jump_en = 1; jump_target = 32'h24;
        tick(); chk("jmp24", pc_out, 32'h24);
        idle();
        trap_en = 1;
        tick(); chk("trap_pc", pc_out, 32'h100);
        chk("trap_epc24", epc, 32'h24);
        idle();
        tick(); chk("trap_seq", pc_out, 32'h104);
        mret_en = 1;
        tick(); chk("mret_pc", pc_out, 32'h24);
        idle();
        tick(); chk("mret_seq", pc_out, 32'h28);
        chk("epc_hold", epc, 32'h24);

        trap_en = 1; mret_en = 1;
        tick(); chk("trap_mret_pc", pc_out, 32'h100);
        chk("trap_mret_epc", epc, 32'h28);
        idle();
        tick(); chk("seq104", pc_out, 32'h104);
        stall = 1; trap_en = 1;
        tick(); chk("trap_stall_pc", pc_out, 32'h100);
        chk("trap_stall_epc", epc, 32'h104);
        idle();

        jump_en = 1; jump_target = 32'h42;
`ifdef PC_RVC_EN
        tick(); chk("rvc_jmp42", pc_out, 32'h42);
        chk("rvc_mis0", {31'b0, misaligned}, 32'h0);
        chk("rvc_epc_keep", epc, 32'h104);
        idle();
        inst_c = 1;
        chk("rvc_plus", pc_plus, 32'h44);
        tick(); chk("rvc_step", pc_out, 32'h44);
        idle();
        jump_en = 1; jump_target = 32'h43;
        tick(); chk("odd_pc", pc_out, 32'h100);
        chk("odd_epc", epc, 32'h43);
        chk("odd_mis", {31'b0, misaligned}, 32'h1);
        idle();
        tick(); chk("odd_after", pc_out, 32'h104);
        chk("odd_mis_clr", {31'b0, misaligned}, 32'h0);
`else
        tick(); chk("mis_pc", pc_out, 32'h100);
        chk("mis_epc", epc, 32'h42);
        chk("mis_flag", {31'b0, misaligned}, 32'h1);
        idle();
        tick(); chk("mis_after", pc_out, 32'h104);
        chk("mis_clr", {31'b0, misaligned}, 32'h0);
        mret_en = 1;
        tick(); chk("mret_mis_pc", pc_out, 32'h100);
        chk("mret_mis_epc", epc, 32'h42);
        chk("mret_mis_flag", {31'b0, misaligned}, 32'h1);
        idle();
        branch_taken = 1; branch_target = 32'h46;
        tick(); chk("br_mis_pc", pc_out, 32'h100);
        chk("br_mis_epc", epc, 32'h46);
        chk("br_mis_flag", {31'b0, misaligned}, 32'h1);
        idle();
        tick(); chk("br_mis_after", pc_out, 32'h104);
        chk("br_mis_clr", {31'b0, misaligned}, 32'h0);
`endif

        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_top", pc_out, 32'hFFFF_FFFC);
        chk("wrap_plus", pc_plus, 32'h0);
        idle();
        tick(); chk("wrap_zero", pc_out, 32'h0);
        tick(); chk("wrap_next", pc_out, 32'h4);

        #3;
        reset = 0;
        #1;
        chk("async_pc", pc_out, 32'h0);
        chk("async_epc", epc, 32'h0);
        chk("async_fv", {31'b0, fetch_valid}, 32'h0);
        tick();
        reset = 1;
        tick();
        chk("reboot_pc", pc_out, 32'h0);
        tick();
        chk("reboot_seq", pc_out, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
